// File: rtl/tx_frame_streamer_pkg.sv
// tx_pkg: shared types and constants for the transmit frame streamer.
package tx_pkg;

  // Streamer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAD  = 2'd2
  } tx_state_e;

  // Default pad target (minimum Ethernet frame without FCS).
  localparam int DEFAULT_MIN_FRAME_LEN = 60;

  // One byte-store entry: payload byte plus its end-of-frame flag.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/tx_frame_streamer_if.sv
// Bundles the byte-write port from the transmit engine and the tx_axis
// stream toward the MAC. "master" is the streamer's view (it sources the
// stream and the buffer flags); "slave" is the peer side (engine + MAC).
interface tx_frame_streamer_if;
  logic       btx_wr_en;
  logic [7:0] btx_wdata;
  logic       btx_last;
  logic       btx_full;
  logic       btx_empty;
  logic [7:0] tx_axis_tdata;
  logic       tx_axis_tvalid;
  logic       tx_axis_tlast;
  logic       tx_axis_tready;
  logic       tx_busy;

  modport master (
    input  btx_wr_en, btx_wdata, btx_last, tx_axis_tready,
    output btx_full, btx_empty, tx_axis_tdata, tx_axis_tvalid,
    output tx_axis_tlast, tx_busy
  );

  modport slave (
    output btx_wr_en, btx_wdata, btx_last, tx_axis_tready,
    input  btx_full, btx_empty, tx_axis_tdata, tx_axis_tvalid,
    input  tx_axis_tlast, tx_busy
  );
endinterface

// File: rtl/tx_fifo_mem.sv
// tx_fifo_mem: simple dual-port SIZE x 9 byte store, one write port and
// one read port whose output register only loads when re is high, so the
// stream byte holds while the MAC stalls.
module tx_fifo_mem
  import tx_pkg::*;
#(
  parameter int SIZE = 2048
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [$clog2(SIZE)-1:0] waddr,
  input  tx_entry_t               wdata,
  input  logic                    re,
  input  logic [$clog2(SIZE)-1:0] raddr,
  output tx_entry_t               rdata
);

  tx_entry_t mem [SIZE];
  tx_entry_t rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Enable-gated registered read port.
  always_ff @(posedge clk) begin
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/tx_frame_streamer.sv
// tx_frame_streamer: store-and-forward transmit buffer. Complete frames are
// written into a circular byte store and drained onto tx_axis only once
// their last byte has landed, so the MAC never underruns mid-frame.
// Optional feature: define TX_PAD_EN to zero-pad short frames up to
// MIN_FRAME_LEN beats.
module tx_frame_streamer
  import tx_pkg::*;
#(
  parameter int SIZE          = 2048,
  parameter int MIN_FRAME_LEN = DEFAULT_MIN_FRAME_LEN
) (
  input logic                 clk,
  input logic                 rst,
  tx_frame_streamer_if.master bus
);

  localparam int AW = $clog2(SIZE);

  // Elaboration-time parameter sanity.
  if ((SIZE < 4) || ((SIZE & (SIZE - 1)) != 0)) begin : g_bad_size
    $error("tx_frame_streamer: SIZE must be a power of two >= 4");
  end
  if ((MIN_FRAME_LEN < 1) || (MIN_FRAME_LEN >= SIZE)) begin : g_bad_min
    $error("tx_frame_streamer: MIN_FRAME_LEN must lie in 1..SIZE-1");
  end

  tx_state_e       state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   frame_cnt_q, frame_cnt_d;

  tx_entry_t       rd_entry;
  logic            rd_en;
  logic            wr_accept;
  logic            commit;
  logic            release_frame;
  logic            beat_hs;
  logic            tvalid;
  logic            tlast;
  logic [7:0]      tdata;

`ifdef TX_PAD_EN
  // Beat counter only feeds the pad comparator.
  localparam logic [AW-1:0] PAD_LAST = AW'(MIN_FRAME_LEN - 1);
  logic [AW-1:0]   byte_cnt_q, byte_cnt_d;
  logic            pad_needed;
  // Current beat number is byte_cnt+1; pad if that is below the target.
  assign pad_needed = (byte_cnt_q < PAD_LAST);
`endif

  // Flags are combinational from the registered pointers.
  assign bus.btx_full  = ((wptr_q + AW'(1)) == rptr_q);
  assign bus.btx_empty = (wptr_q == rptr_q);

  assign wr_accept     = bus.btx_wr_en & ~bus.btx_full;
  assign commit        = wr_accept & bus.btx_last;
  assign beat_hs       = tvalid & bus.tx_axis_tready;
  assign release_frame = beat_hs & tlast;

  tx_fifo_mem #(.SIZE(SIZE)) u_mem (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (wptr_q),
    .wdata ('{last: bus.btx_last, data: bus.btx_wdata}),
    .re    (rd_en),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );

  // State and datapath registers; reset aborts any frame and empties the store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      frame_cnt_q <= '0;
`ifdef TX_PAD_EN
      byte_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef TX_PAD_EN
      byte_cnt_q  <= byte_cnt_d;
`endif
    end
  end

  // Write pointer and committed-frame count bookkeeping.
  always_comb begin
    wptr_d = wr_accept ? (wptr_q + AW'(1)) : wptr_q;
    case ({commit, release_frame})
      2'b10:   frame_cnt_d = frame_cnt_q + AW'(1);
      2'b01:   frame_cnt_d = frame_cnt_q - AW'(1);
      default: frame_cnt_d = frame_cnt_q;
    endcase
  end

  // Next-state logic: prefetch the next entry on every accepted non-last beat.
  always_comb begin
    state_d = state_q;
    rptr_d  = rptr_q;
    rd_en   = 1'b0;
`ifdef TX_PAD_EN
    byte_cnt_d = byte_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (frame_cnt_q != '0) begin
          rd_en   = 1'b1;
          rptr_d  = rptr_q + AW'(1);
          state_d = SEND;
`ifdef TX_PAD_EN
          byte_cnt_d = '0;
`endif
        end
      end
      SEND: begin
        if (beat_hs) begin
`ifdef TX_PAD_EN
          byte_cnt_d = byte_cnt_q + AW'(1);
`endif
          if (!rd_entry.last) begin
            // Frame is committed, so the following byte is already stored.
            rd_en  = 1'b1;
            rptr_d = rptr_q + AW'(1);
          end else begin
`ifdef TX_PAD_EN
            state_d = pad_needed ? PAD : IDLE;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef TX_PAD_EN
      PAD: begin
        if (beat_hs) begin
          byte_cnt_d = byte_cnt_q + AW'(1);
          if (tlast) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    tvalid = 1'b0;
    tdata  = 8'h00;
    tlast  = 1'b0;
    case (state_q)
      SEND: begin
        tvalid = 1'b1;
        tdata  = rd_entry.data;
`ifdef TX_PAD_EN
        tlast  = rd_entry.last & ~pad_needed;
`else
        tlast  = rd_entry.last;
`endif
      end
`ifdef TX_PAD_EN
      PAD: begin
        tvalid = 1'b1;
        tlast  = (byte_cnt_q == PAD_LAST);
      end
`endif
      default: ;
    endcase
  end

  assign bus.tx_axis_tvalid = tvalid;
  assign bus.tx_axis_tdata  = tdata;
  assign bus.tx_axis_tlast  = tlast;
  assign bus.tx_busy        = (state_q != IDLE);

endmodule

// File: doc/tx_frame_streamer.md
# tx_frame_streamer

Transmit-side frame buffer for the tri-mode Ethernet MAC datapath. It accepts payload bytes from the transmit engine, stores complete frames in a circular byte store, and drains each committed frame onto the MAC's `tx_axis` AXI-Stream slave with full `tready` backpressure. Frames are store-and-forward: a frame is never started until its last byte is in the buffer, so the MAC never sees an underrun mid-frame.

## Interface
Parameters:
- `SIZE`, default 2048: byte-store depth; must be a power of two. Usable capacity is SIZE-1.
- `MIN_FRAME_LEN`, default 60: pad target in bytes. Used only with `TX_PAD_EN`.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `btx_wr_en`  in  1  write strobe for `btx_wdata`.
- `btx_wdata`  in  8  payload byte.
- `btx_last`  in  1  marks the byte written this cycle as the final byte of its frame.
- `btx_full`  out  1  store holds SIZE-1 bytes; writes are dropped.
- `btx_empty`  out  1  store holds no bytes.
- `tx_axis_tdata`  out  8  stream byte.
- `tx_axis_tvalid`  out  1  stream valid.
- `tx_axis_tlast`  out  1  final beat of the frame.
- `tx_axis_tready`  in  1  MAC accepts the beat.
- `tx_busy`  out  1  FSM is not in IDLE.

## Operation
- Each store entry is 9 bits: the data byte plus the `btx_last` flag.
- **Write path:**
  - A write is accepted when `btx_wr_en & !btx_full`.
  - An accepted write stores the entry at `wptr` and increments `wptr`, which wraps modulo SIZE.
  - A write while full is silently discarded.
- **Flags:** `btx_full` = (`wptr`+1 == `rptr`). `btx_empty` = (`wptr` == `rptr`).
- **Frame count:** `frame_cnt` ($clog2(SIZE) bits) increments on each accepted write with `btx_last`=1, and decrements on each tlast handshake. When both happen in the same cycle, the count is unchanged.
- **States:**
  - IDLE: `tvalid`=0. If `frame_cnt`≠0: read the entry at `rptr`, increment `rptr`, clear `byte_cnt`, and go to SEND.
  - SEND: `tvalid`=1 and `tdata` comes from the read register. On a handshake (`tvalid&tready`), `byte_cnt` increments.
    - If the current entry's last flag is 0: read the next entry and increment `rptr`. This gives back-to-back beats; the next entry is guaranteed to be present.
    - If the last flag is 1 and no padding is required: go to IDLE and decrement `frame_cnt`.
    - If padding is required: go to PAD.
  - PAD (only with `TX_PAD_EN`): `tvalid`=1, `tdata`=0x00. On each handshake `byte_cnt` increments. `tlast` is asserted when `byte_cnt` == MIN_FRAME_LEN-1. The tlast handshake returns the FSM to IDLE and decrements `frame_cnt`.
- **Stability:** while `tvalid`=1 and `tready`=0, `tdata` and `tlast` hold stable and no read is issued.
- **Frame length:** upstream guarantees every frame is ≤ SIZE-1 bytes. A longer frame fills the store without committing and stalls the block; recovery is by reset.

## Timing
- Reset values: `tvalid`=0, `tlast`=0, `tdata`=0x00, `btx_full`=0, `btx_empty`=1, `tx_busy`=0. Pointers, `frame_cnt` and `byte_cnt` are 0 and the FSM is in IDLE.
- Reset asserted mid-frame aborts the frame immediately. `tvalid` drops asynchronously and all stored data is discarded.
- Latency: if the write with `btx_last` is accepted at edge k, `tvalid` is high from edge k+1. This assumes the FSM was idle.
- Throughput: one beat per cycle while `tready`=1.
- Inter-frame gap: at least one `tvalid`=0 cycle (IDLE) between frames.
- Writes and reads are independent. A write to an empty store in the same cycle as a read of the last remaining byte is legal.
- `btx_full` and `btx_empty` are combinational from registered pointers. They update the cycle after the causing edge.

## Configuration
- `TX_PAD_EN` defined:
  - A frame shorter than MIN_FRAME_LEN bytes is extended with 0x00 beats to exactly MIN_FRAME_LEN beats.
  - `tlast` is suppressed on the stored last byte and asserted on beat MIN_FRAME_LEN.
  - Frames of MIN_FRAME_LEN or more bytes pass unchanged.
- `TX_PAD_EN` undefined: the PAD state and its comparator are not compiled. `tlast` equals the stored last flag.

## Structure
- Package `tx_pkg` holds:
  - the state enum `tx_state_e` {IDLE, SEND, PAD};
  - `DEFAULT_MIN_FRAME_LEN` = 60;
  - the 9-bit entry struct `tx_entry_t` {last, data}.
- Sub-module `tx_fifo_mem` is a simple dual-port SIZE×9 RAM with a registered, enable-gated read port. Pointers, flags and the FSM live in `tx_frame_streamer`.

## Test plan
- Reset: assert `rst` mid-frame with `tvalid`=1. Required: `tvalid`=0 immediately, `btx_empty`=1, `tx_busy`=0, and no further beats after deassertion.
- Single frame: write bytes 0x00..0x3F with `btx_last` on 0x3F, `tready`=1. Required: 64 beats in order, `tvalid` high from the edge after the commit, `tlast` only on 0x3F.
- Backpressure: drop `tready` for 5 cycles at beat 20. Required: `tdata`=0x13 held stable throughout, no beat lost or duplicated.
- Padding: write a 10-byte frame 0xA0..0xA9.
  - With `TX_PAD_EN`: 60 beats, beats 11..60 = 0x00, `tlast` on beat 60.
  - Without `TX_PAD_EN`: 10 beats, `tlast` on 0xA9.
- Full: hold `tready`=0 and write a 2047-byte frame, then one extra byte. Required: `btx_full`=1 after the 2047th write, the extra byte dropped, then exactly 2047 beats once `tready`=1.
- Overlap: commit a second frame during the first frame's final beat (simultaneous `frame_cnt` increment and decrement). Required: `frame_cnt` stays 1, and the second frame starts after one idle cycle.
